updown_sweep_ctrl: RTL and testbench
====================================

Name: updown_sweep_ctrl

Overview:
- Sequencer for a 4-bit up/down count datapath.
- Owns the count register and drives the direction output.
- Runs programmable triangle sweeps: ramp up from lo_lim to hi_lim, dwell, ramp down, dwell, repeated N times or continuously.
- Used wherever a bounded up/down sweep with dwell must be scheduled without per-cycle software control of up_down.

Parameters:
- WIDTH, 4, width of count, lo_lim, hi_lim
- DWELL_W, 8, width of dwell_cyc and the internal dwell counter
- SWP_W, 4, width of num_sweeps and the internal sweeps-remaining counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin sweep; sampled only in IDLE
- stop  input  1  abort sweep; honoured in any state
- lo_lim  input  WIDTH  sweep floor
- hi_lim  input  WIDTH  sweep ceiling
- dwell_cyc  input  DWELL_W  extra hold cycles at each limit
- num_sweeps  input  SWP_W  full triangles to run; 0 = continuous
- count  output  WIDTH  current count value (registered)
- up_down  output  1  1 = up phase (RAMP_UP/DWELL_HI/IDLE), 0 = down phase
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse on normal completion
- aborted  output  1  one-cycle pulse when stop terminates a sweep
- cfg_err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: state IDLE, count=0, up_down=1, busy=0, done=0, aborted=0, cfg_err=0; internal counters cleared. Reset applied mid-sweep takes effect at the next edge, with no done or aborted pulse.
- All outputs are registered. done, aborted and cfg_err are high for exactly one cycle.
- States: IDLE, RAMP_UP, DWELL_HI, RAMP_DOWN, DWELL_LO.
- IDLE + start, lo_lim >= hi_lim: cfg_err pulse, stay IDLE, count unchanged.
- IDLE + start, lo_lim < hi_lim: latch lo/hi/dwell/num_sweeps. Next cycle: RAMP_UP, count=lo_lim. Input changes after latch are ignored until IDLE.
- RAMP_UP:
  - count <= count+1 each cycle.
  - When count+1 == hi_lim, next state is DWELL_HI (count=hi_lim).
  - Values driven: lo..hi-1.
- DWELL_HI: count held; dwell counter starts at 0; stay dwell_cyc+1 cycles, then RAMP_DOWN with count unchanged (=hi).
- RAMP_DOWN: count <= count-1; when count-1 == lo_lim, next state is DWELL_LO (count=lo). Values driven: hi..lo+1.
- DWELL_LO:
  - Held dwell_cyc+1 cycles.
  - At exit, one sweep is complete.
  - If num_sweeps==0, or sweeps remaining > 1: decrement the remaining count (continuous mode does not count), go to RAMP_UP with count unchanged.
  - Otherwise: go to IDLE with done=1, count stays at lo.
- Timing:
  - One triangle = 2*(hi-lo) + 2*(dwell_cyc+1) busy cycles.
  - busy rises the cycle after start is accepted and falls in the same cycle done pulses.
- up_down is 0 in RAMP_DOWN and DWELL_LO, and 1 in all other states.
- stop in any non-IDLE state: next cycle IDLE, aborted=1, count frozen at its current value, no done.
  - stop beats a simultaneous end-of-sweep: aborted, not done.
- stop and start together in IDLE: start is ignored, no pulses.
- start while busy: ignored.
- No wrap-around: count is always within [lo, hi]; arithmetic cannot overflow because limits are checked at start.

Optional Feature:
- Macro: SWEEP_PAUSE_EN.
- Defined: adds input port pause (1 bit). While pause=1 in a non-IDLE state, state, count, dwell counter and sweep counter all freeze; busy stays 1. stop is still honoured while paused. pause has no effect in IDLE.
- Undefined: no pause port; behaviour is identical to pause tied 0.

Test Plan:
- Reset and idle:
  - rst=1 for 2 cycles, then 0 -> count=0, up_down=1, busy=0, all pulses 0.
  - start=1 with lo=5, hi=5 -> cfg_err pulses once, busy stays 0.
- Single sweep:
  - Stimulus: lo=2, hi=5, dwell_cyc=1, num_sweeps=1, start pulse at cycle 0.
  - Required count c1..c10: 2,3,4,5,5,5,4,3,2,2.
  - Required up_down: 1 for c1-c5, 0 for c6-c10.
  - c11: IDLE, done=1, busy=0, count=2.
- Repeat and continuous:
  - lo=0, hi=1, dwell_cyc=0, num_sweeps=3 -> count pattern 0,1,1,0 repeated 3 times, busy for 12 cycles, one done.
  - num_sweeps=0 -> sweeps continue for 100 cycles with no done.
- Abort:
  - During RAMP_DOWN at count=4, stop=1 -> next cycle IDLE, aborted=1, count=4, no done.
  - stop asserted on the final DWELL_LO cycle -> aborted=1, done=0.
- Mid-operation edge cases:
  - rst=1 during DWELL_HI -> next cycle full reset values.
  - start while busy -> no change to sequence.
  - Changing lo_lim/hi_lim mid-sweep -> no effect on the current sweep.
- SWEEP_PAUSE_EN build:
  - pause=1 for 3 cycles at count=3 in RAMP_UP -> count holds 3 for 3 cycles, then resumes 4, 5.
  - Total busy length is extended by exactly 3 cycles.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// rtl/updown_sweep_ctrl.sv - bounded triangle sweep sequencer owning a 4-bit up/down count
// Optional SWEEP_PAUSE_EN adds a pause input that freezes an active sweep.
module updown_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 8,
    parameter int SWP_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
`ifdef SWEEP_PAUSE_EN
    input  logic               pause,
`endif
    input  logic [WIDTH-1:0]   lo_lim,
    input  logic [WIDTH-1:0]   hi_lim,
    input  logic [DWELL_W-1:0] dwell_cyc,
    input  logic [SWP_W-1:0]   num_sweeps,
    output logic [WIDTH-1:0]   count,
    output logic               up_down,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               cfg_err
);

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        DWELL_HI,
        RAMP_DOWN,
        DWELL_LO
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   hi_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [SWP_W-1:0]   nsw_r;
    logic [SWP_W-1:0]   sw_rem;
    logic [WIDTH-1:0]   cnt_inc;
    logic [WIDTH-1:0]   cnt_dec;
    logic               hold;

`ifdef SWEEP_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Limits are validated at start, so these never wrap inside a sweep.
    assign cnt_inc = count + {{(WIDTH-1){1'b0}}, 1'b1};
    assign cnt_dec = count - {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            up_down   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cfg_err   <= 1'b0;
            lo_r      <= '0;
            hi_r      <= '0;
            dwell_r   <= '0;
            dwell_cnt <= '0;
            nsw_r     <= '0;
            sw_rem    <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            cfg_err <= 1'b0;
            if (state == IDLE) begin
                if (start && !stop) begin
                    if (lo_lim >= hi_lim) begin
                        cfg_err <= 1'b1;
                    end else begin
                        lo_r      <= lo_lim;
                        hi_r      <= hi_lim;
                        dwell_r   <= dwell_cyc;
                        nsw_r     <= num_sweeps;
                        sw_rem    <= num_sweeps;
                        dwell_cnt <= '0;
                        count     <= lo_lim;
                        state     <= RAMP_UP;
                        up_down   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
            end else if (stop) begin
                // Abort wins over everything, including a simultaneous end of sweep.
                state   <= IDLE;
                aborted <= 1'b1;
                busy    <= 1'b0;
                up_down <= 1'b1;
            end else if (!hold) begin
                case (state)
                    RAMP_UP: begin
                        count <= cnt_inc;
                        if (cnt_inc == hi_r) begin
                            state     <= DWELL_HI;
                            dwell_cnt <= '0;
                        end
                    end
                    DWELL_HI: begin
                        if (dwell_cnt == dwell_r) begin
                            state   <= RAMP_DOWN;
                            up_down <= 1'b0;
                        end else begin
                            dwell_cnt <= dwell_cnt + {{(DWELL_W-1){1'b0}}, 1'b1};
                        end
                    end
                    RAMP_DOWN: begin
                        count <= cnt_dec;
                        if (cnt_dec == lo_r) begin
                            state     <= DWELL_LO;
                            dwell_cnt <= '0;
                        end
                    end
                    DWELL_LO: begin
                        if (dwell_cnt == dwell_r) begin
                            if (nsw_r == '0 || sw_rem > {{(SWP_W-1){1'b0}}, 1'b1}) begin
                                if (nsw_r != '0)
                                    sw_rem <= sw_rem - {{(SWP_W-1){1'b0}}, 1'b1};
                                state   <= RAMP_UP;
                                up_down <= 1'b1;
                            end else begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                up_down <= 1'b1;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + {{(DWELL_W-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        up_down <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb/tb_updown_sweep_ctrl.sv - scoreboard bench for updown_sweep_ctrl
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
`ifdef SWEEP_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic [3:0] lo_lim = '0;
    logic [3:0] hi_lim = '0;
    logic [7:0] dwell_cyc = '0;
    logic [3:0] num_sweeps = '0;
    logic [3:0] count;
    logic       up_down, busy, done, aborted, cfg_err;

    typedef struct packed {
        logic [3:0] c;
        logic       ud;
        logic       b;
        logic       d;
        logic       a;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   stim_done = 1'b0;

    // Hand-derived single sweep lo=2 hi=5 dwell=1, cycles c1..c10
    logic [3:0] tab [10] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2, 4'd2};

    always #5 clk = ~clk;

    updown_sweep_ctrl dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
`ifdef SWEEP_PAUSE_EN
        .pause(pause),
`endif
        .lo_lim(lo_lim),
        .hi_lim(hi_lim),
        .dwell_cyc(dwell_cyc),
        .num_sweeps(num_sweeps),
        .count(count),
        .up_down(up_down),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .cfg_err(cfg_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] c, input logic ud, input logic b,
                        input logic d, input logic a, input logic e);
        exp_t x;
        x.c = c; x.ud = ud; x.b = b; x.d = d; x.a = a; x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic push_tab(input int n);
        for (int k = 0; k < n; k++)
            push(tab[k], (k < 5) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_tri01();
        push(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input logic [3:0] lo, input logic [3:0] hi,
                       input logic [7:0] dw, input logic [3:0] n);
        lo_lim = lo; hi_lim = hi; dwell_cyc = dw; num_sweeps = n;
    endtask

    // Stimulus
    initial begin
        tick(); tick();
        rst = 1'b0;
        tick(); tick();

        // lo == hi rejected
        cfg(4'd5, 4'd5, 8'd0, 4'd1);
        push(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();

        // start with stop in IDLE: nothing happens
        cfg(4'd2, 4'd5, 8'd1, 4'd1);
        start = 1'b1; stop = 1'b1; tick();
        start = 1'b0; stop = 1'b0;
        tick(); tick();

        // single sweep, inputs changed and start re-asserted mid-sweep
        push_tab(10);
        push(4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        start = 1'b1; tick();
        start = 1'b0;
        cfg(4'd0, 4'd9, 8'd7, 4'd5);
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();

        // three sweeps 0..1
        cfg(4'd0, 4'd1, 8'd0, 4'd3);
        for (int s = 0; s < 3; s++) push_tri01();
        push(4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (15) tick();

        // continuous for 100 cycles, then stop
        cfg(4'd0, 4'd1, 8'd0, 4'd0);
        for (int s = 0; s < 25; s++) push_tri01();
        push(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (99) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        tick(); tick();

        // stop in RAMP_DOWN at count 4
        cfg(4'd2, 4'd5, 8'd1, 4'd1);
        push_tab(7);
        push(4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        tick(); tick();

        // stop on final DWELL_LO cycle
        push_tab(10);
        push(4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (9) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        tick(); tick();

        // reset during DWELL_HI: silent return to reset values
        push_tab(4);
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); tick();

        // reset left count at 0: a rejected start shows it
        cfg(4'd7, 4'd3, 8'd0, 4'd1);
        push(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();

`ifdef SWEEP_PAUSE_EN
        // pause three cycles at count 3
        cfg(4'd2, 4'd5, 8'd1, 4'd1);
        push_tab(2);
        repeat (3) push(4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 2; k < 10; k++)
            push(tab[k], (k < 5) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        pause = 1'b1; repeat (3) tick(); pause = 1'b0;
        repeat (12) tick();
`endif

        stim_done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin : monitor
        exp_t got;
        exp_t e;
        int   cyc;
        cyc = 0;
        wait (rst == 1'b0);
        @(negedge clk);
        got = {count, up_down, busy, done, aborted, cfg_err};
        total++;
        if (got != {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got count=%0d ud=%0b busy=%0b done=%0b ab=%0b cfg=%0b, need count=0 ud=1 others 0",
                     got.c, got.ud, got.b, got.d, got.a, got.e);
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (stim_done) break;
            if (cyc > 20000) begin
                total++; bad++;
                $display("FAIL timeout: stimulus not finished after %0d cycles", cyc);
                break;
            end
            if (busy || done || aborted || cfg_err) begin
                got = {count, up_down, busy, done, aborted, cfg_err};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output t=%0t: got count=%0d ud=%0b busy=%0b done=%0b ab=%0b cfg=%0b, need no activity",
                             $time, got.c, got.ud, got.b, got.d, got.a, got.e);
                end else begin
                    e = exp_q.pop_front();
                    if (got != e) begin
                        bad++;
                        $display("FAIL cycle_vector t=%0t: got count=%0d ud=%0b busy=%0b done=%0b ab=%0b cfg=%0b, need count=%0d ud=%0b busy=%0b done=%0b ab=%0b cfg=%0b",
                                 $time, got.c, got.ud, got.b, got.d, got.a, got.e,
                                 e.c, e.ud, e.b, e.d, e.a, e.e);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_outputs: got %0d expected vectors unconsumed, need 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
